// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and types for the pipeline stall/bubble sequencer.
package pipe_hazard_ctrl_pkg;

  // Y86 instruction codes referenced by the hazard terms
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register id meaning "no register"
  localparam logic [3:0] RNONE = 4'hF;

  // Status code for a normally flowing instruction
  localparam logic [2:0] SAOK = 3'd1;

  // Sequencer states; the encoding is visible on state_o
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_IMISS = 2'd1,
    S_DMISS = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Control bundle for the five pipeline registers
  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic d_bubble;
    logic e_stall;
    logic e_bubble;
    logic m_stall;
    logic m_bubble;
    logic w_stall;
  } ctrl_t;

  // Every register held, nothing injected
  localparam ctrl_t CTRL_FREEZE = '{
    f_stall:  1'b1,
    d_stall:  1'b1,
    d_bubble: 1'b0,
    e_stall:  1'b1,
    e_bubble: 1'b0,
    m_stall:  1'b1,
    m_bubble: 1'b0,
    w_stall:  1'b1
  };

  // True for instructions that load a register from memory
  function automatic logic is_load(input logic [3:0] icode);
    return (icode == IMRMOVQ) || (icode == IPOPQ);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, hold once every bit is set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/bubble sequencer for the five-stage Y86 pipeline.
// Cache handshake: icache_ready_i / dcache_ready_i are sampled every cycle;
// a cycle with ready low is a miss cycle, the first cycle with ready high
// completes the access. Decisions are combinational in the cycle the
// condition is seen and the state register moves at the next posedge.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       E_dstM_i,
  input  logic             e_Cnd_i,
  input  logic             E_branch_taken_i,
  input  logic [3:0]       M_icode_i,
  input  logic [2:0]       m_stat_i,
  input  logic [2:0]       W_stat_i,
  input  logic             icache_ready_i,
  input  logic             M_mem_req_i,
  input  logic             dcache_ready_i,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             D_bubble_o,
  output logic             E_stall_o,
  output logic             E_bubble_o,
  output logic             M_stall_o,
  output logic             M_bubble_o,
  output logic             W_stall_o,
  output logic [1:0]       state_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  state_t     state;
  state_t     state_nxt;
  logic       load_use;
  logic       ret_pend;
  logic       mispred;
  logic       icache_miss;
  logic       dcache_miss;
  logic       w_fault;
  ctrl_t      run_ctrl;
  ctrl_t      ctrl;
  logic [7:0] ctrl_bits;
  logic       stall_inc;
  logic       mispred_inc;

  // Hazard terms from the decode/execute/memory/writeback registers
  always_comb begin
    load_use    = is_load(E_icode_i) && (E_dstM_i != RNONE) &&
                  ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    ret_pend    = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
    mispred     = (E_icode_i == IJXX) && (e_Cnd_i != E_branch_taken_i);
    icache_miss = ~icache_ready_i;
    dcache_miss = M_mem_req_i & ~dcache_ready_i;
    w_fault     = (W_stat_i != SAOK);
  end

  // Normal-flow pipeline control; a mispredict squashes D rather than holding it
  always_comb begin
    run_ctrl          = '0;
    run_ctrl.f_stall  = load_use | ret_pend | icache_miss;
    run_ctrl.d_stall  = load_use & ~mispred;
    run_ctrl.d_bubble = mispred | (ret_pend & ~load_use) |
                        (icache_miss & ~load_use & ~mispred);
    run_ctrl.e_bubble = mispred | load_use;
    run_ctrl.m_bubble = (m_stat_i != SAOK) | w_fault;
  end

  // State register; reset returns to RUN regardless of any cache access in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and output selection; a faulting writeback overrides everything
  always_comb begin
    state_nxt = state;
    ctrl      = run_ctrl;
    case (state)
      S_RUN, S_IMISS: begin
        if (w_fault) begin
          state_nxt = S_HALT;
        end else if (dcache_miss) begin
          state_nxt = S_DMISS;
        end else if (icache_miss) begin
          state_nxt = S_IMISS;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_DMISS: begin
        // The cycle ready returns already flows with normal control
        if (!dcache_ready_i) begin
          ctrl = CTRL_FREEZE;
        end
        if (w_fault) begin
          state_nxt = S_HALT;
        end else if (dcache_ready_i) begin
          state_nxt = S_RUN;
        end
      end
      S_HALT: begin
        ctrl      = CTRL_FREEZE;
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_RUN;
      end
    endcase
  end

  assign F_stall_o  = ctrl.f_stall;
  assign D_stall_o  = ctrl.d_stall;
  assign D_bubble_o = ctrl.d_bubble;
  assign E_stall_o  = ctrl.e_stall;
  assign E_bubble_o = ctrl.e_bubble;
  assign M_stall_o  = ctrl.m_stall;
  assign M_bubble_o = ctrl.m_bubble;
  assign W_stall_o  = ctrl.w_stall;
  assign state_o    = state;
  assign halted_o   = (state == S_HALT);

  // Lost cycles exclude the frozen halt; mispredicts count only while the pipe can act on them
  assign ctrl_bits   = ctrl;
  assign stall_inc   = (state != S_HALT) && (|ctrl_bits);
  assign mispred_inc = mispred && ((state == S_RUN) || (state == S_IMISS));

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (stall_inc),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (mispred_inc),
    .count (mispred_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed pinned scenarios plus random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic [3:0] D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, M_icode_i;
  logic       e_Cnd_i, E_branch_taken_i, icache_ready_i, M_mem_req_i, dcache_ready_i;
  logic [2:0] m_stat_i, W_stat_i;

  logic        F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o, M_stall_o, M_bubble_o, W_stall_o;
  logic [1:0]  state_o;
  logic        halted_o;
  logic [31:0] stall_cnt_o, mispred_cnt_o;

  logic        s_F_stall, s_D_stall, s_D_bubble, s_E_stall, s_E_bubble, s_M_stall, s_M_bubble, s_W_stall;
  logic [1:0]  s_state;
  logic        s_halted;
  logic [3:0]  s_stall_cnt, s_mispred_cnt;

  pipe_hazard_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .D_icode_i(D_icode_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
    .E_icode_i(E_icode_i), .E_dstM_i(E_dstM_i), .e_Cnd_i(e_Cnd_i),
    .E_branch_taken_i(E_branch_taken_i), .M_icode_i(M_icode_i),
    .m_stat_i(m_stat_i), .W_stat_i(W_stat_i), .icache_ready_i(icache_ready_i),
    .M_mem_req_i(M_mem_req_i), .dcache_ready_i(dcache_ready_i),
    .F_stall_o(F_stall_o), .D_stall_o(D_stall_o), .D_bubble_o(D_bubble_o),
    .E_stall_o(E_stall_o), .E_bubble_o(E_bubble_o), .M_stall_o(M_stall_o),
    .M_bubble_o(M_bubble_o), .W_stall_o(W_stall_o), .state_o(state_o),
    .halted_o(halted_o), .stall_cnt_o(stall_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst_i),
    .D_icode_i(D_icode_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
    .E_icode_i(E_icode_i), .E_dstM_i(E_dstM_i), .e_Cnd_i(e_Cnd_i),
    .E_branch_taken_i(E_branch_taken_i), .M_icode_i(M_icode_i),
    .m_stat_i(m_stat_i), .W_stat_i(W_stat_i), .icache_ready_i(icache_ready_i),
    .M_mem_req_i(M_mem_req_i), .dcache_ready_i(dcache_ready_i),
    .F_stall_o(s_F_stall), .D_stall_o(s_D_stall), .D_bubble_o(s_D_bubble),
    .E_stall_o(s_E_stall), .E_bubble_o(s_E_bubble), .M_stall_o(s_M_stall),
    .M_bubble_o(s_M_bubble), .W_stall_o(s_W_stall), .state_o(s_state),
    .halted_o(s_halted), .stall_cnt_o(s_stall_cnt), .mispred_cnt_o(s_mispred_cnt)
  );

  // ---------------- behavioural model ----------------
  // Modes: 0 normal, 1 waiting on fetch, 2 waiting on data, 3 frozen.
  int     m_mode;
  longint m_st, m_mp;
  int     n_checks = 0;
  int     n_fail   = 0;
  logic [31:0] exp_q[$];

  // Stage-register control the rules demand for the current inputs and mode.
  // Bit order: F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall.
  function automatic logic [7:0] model_flags(input int mode);
    bit lu, rp, mp, im;
    bit f, ds, db, eb, mb;
    lu = ((E_icode_i == 4'h5) || (E_icode_i == 4'hB)) && (E_dstM_i != 4'hF) &&
         ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    rp = (D_icode_i == 4'h9) || (E_icode_i == 4'h9) || (M_icode_i == 4'h9);
    mp = (E_icode_i == 4'h7) && (e_Cnd_i != E_branch_taken_i);
    im = !icache_ready_i;
    if (mode == 3) return 8'b1101_0101;
    if (mode == 2 && !dcache_ready_i) return 8'b1101_0101;
    f  = lu || rp || im;
    ds = lu && !mp;
    db = mp || (rp && !lu) || (im && !lu && !mp);
    eb = mp || lu;
    mb = (m_stat_i != 3'd1) || (W_stat_i != 3'd1);
    return {f, ds, db, 1'b0, eb, 1'b0, mb, 1'b0};
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [31:0] pin(input logic [7:0] f, input logic h, input logic [1:0] s,
                                      input logic [3:0] sc, input logic [7:0] st, input logic [7:0] mp);
    return {f, h, s, sc, st, mp, 1'b0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [7:0]  ef;
    logic [31:0] w;
    bit          mis;
    if (rst_i) begin
      m_mode = 0;
      m_st   = 0;
      m_mp   = 0;
    end
    ef = model_flags(m_mode);
    check("flags", {F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o, M_stall_o, M_bubble_o, W_stall_o}, ef);
    check("sat_flags", {s_F_stall, s_D_stall, s_D_bubble, s_E_stall, s_E_bubble, s_M_stall, s_M_bubble, s_W_stall}, ef);
    check("state", state_o, m_mode);
    check("halted", halted_o, (m_mode == 3));
    check("stall_cnt", stall_cnt_o, sat(m_st, 64'hFFFF_FFFF));
    check("mispred_cnt", mispred_cnt_o, sat(m_mp, 64'hFFFF_FFFF));
    check("sat_stall_cnt", s_stall_cnt, sat(m_st, 15));
    check("sat_mispred_cnt", s_mispred_cnt, sat(m_mp, 15));
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      check("pinned", {F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o, M_stall_o, M_bubble_o,
                       W_stall_o, halted_o, state_o, s_stall_cnt, stall_cnt_o[7:0], mispred_cnt_o[7:0], 1'b0}, w);
    end
    // advance the model to what the next rising edge produces
    mis = (E_icode_i == 4'h7) && (e_Cnd_i != E_branch_taken_i);
    if (m_mode != 3 && ef != 8'h00) m_st++;
    if (mis && m_mode < 2) m_mp++;
    if (m_mode != 3) begin
      if (W_stat_i != 3'd1)                                m_mode = 3;
      else if (m_mode == 2)                                m_mode = dcache_ready_i ? 0 : 2;
      else if (M_mem_req_i && !dcache_ready_i)             m_mode = 2;
      else if (!icache_ready_i)                            m_mode = 1;
      else                                                 m_mode = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    D_icode_i = 4'h1; E_icode_i = 4'h1; M_icode_i = 4'h1;
    d_srcA_i = 4'hF; d_srcB_i = 4'hF; E_dstM_i = 4'hF;
    e_Cnd_i = 1'b0; E_branch_taken_i = 1'b0;
    m_stat_i = 3'd1; W_stat_i = 3'd1;
    icache_ready_i = 1'b1; M_mem_req_i = 1'b0; dcache_ready_i = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous pulse that never overlaps a rising edge
  task automatic reset_pulse();
    @(posedge clk);
    #1 set_idle();
    #1 rst_i = 1'b1;
    @(negedge clk);
    #2 rst_i = 1'b0;
  endtask

  task automatic drive_random();
    logic [3:0] ic_tab [8];
    ic_tab = '{4'h1, 4'h5, 4'hB, 4'h7, 4'h9, 4'h6, 4'h2, 4'h8};
    D_icode_i = ic_tab[$urandom_range(0, 7)];
    E_icode_i = ic_tab[$urandom_range(0, 7)];
    M_icode_i = ic_tab[$urandom_range(0, 7)];
    E_dstM_i  = 4'($urandom_range(0, 15));
    d_srcA_i  = ($urandom_range(0, 1) == 0) ? E_dstM_i : 4'($urandom_range(0, 15));
    d_srcB_i  = ($urandom_range(0, 3) == 0) ? E_dstM_i : 4'($urandom_range(0, 15));
    e_Cnd_i   = 1'($urandom_range(0, 1));
    E_branch_taken_i = 1'($urandom_range(0, 1));
    m_stat_i  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
    W_stat_i  = ($urandom_range(0, 199) == 0) ? 3'd2 : 3'd1;
    icache_ready_i = ($urandom_range(0, 9) != 0);
    M_mem_req_i    = ($urandom_range(0, 2) == 0);
    dcache_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    rst_i = 1'b1;
    @(negedge clk);
    #2 rst_i = 1'b0;

    // load-use: one cycle of F/D stall plus E bubble
    reset_pulse();
    step(); E_icode_i = 4'h5; E_dstM_i = 4'h3; d_srcA_i = 4'h3;
    exp_q.push_back(pin(8'hC8, 1'b0, 2'd0, 4'd0, 8'd0, 8'd0));
    step(); set_idle();
    exp_q.push_back(pin(8'h00, 1'b0, 2'd0, 4'd1, 8'd1, 8'd0));

    // mispredict: predicted taken, resolved not taken
    reset_pulse();
    step(); E_icode_i = 4'h7; E_branch_taken_i = 1'b1; e_Cnd_i = 1'b0;
    exp_q.push_back(pin(8'h28, 1'b0, 2'd0, 4'd0, 8'd0, 8'd0));
    step(); set_idle();
    exp_q.push_back(pin(8'h00, 1'b0, 2'd0, 4'd1, 8'd1, 8'd1));

    // ret walking D, E, M
    reset_pulse();
    step(); D_icode_i = 4'h9;
    exp_q.push_back(pin(8'hA0, 1'b0, 2'd0, 4'd0, 8'd0, 8'd0));
    step(); D_icode_i = 4'h1; E_icode_i = 4'h9;
    exp_q.push_back(pin(8'hA0, 1'b0, 2'd0, 4'd1, 8'd1, 8'd0));
    step(); E_icode_i = 4'h1; M_icode_i = 4'h9;
    exp_q.push_back(pin(8'hA0, 1'b0, 2'd0, 4'd2, 8'd2, 8'd0));
    step(); set_idle();
    exp_q.push_back(pin(8'h00, 1'b0, 2'd0, 4'd3, 8'd3, 8'd0));

    // dcache miss: decision cycle flows, then five frozen cycles, release on ready
    reset_pulse();
    step(); M_mem_req_i = 1'b1; dcache_ready_i = 1'b0;
    exp_q.push_back(pin(8'h00, 1'b0, 2'd0, 4'd0, 8'd0, 8'd0));
    for (int i = 0; i < 5; i++) begin
      step();
      exp_q.push_back(pin(8'hD5, 1'b0, 2'd2, 4'(i), 8'(i), 8'd0));
    end
    step(); dcache_ready_i = 1'b1;
    exp_q.push_back(pin(8'h00, 1'b0, 2'd2, 4'd5, 8'd5, 8'd0));
    step(); set_idle();
    exp_q.push_back(pin(8'h00, 1'b0, 2'd0, 4'd5, 8'd5, 8'd0));

    // exception: halt is sticky, only reset leaves it
    reset_pulse();
    step(); W_stat_i = 3'd2;
    exp_q.push_back(pin(8'h02, 1'b0, 2'd0, 4'd0, 8'd0, 8'd0));
    step(); set_idle();
    exp_q.push_back(pin(8'hD5, 1'b1, 2'd3, 4'd1, 8'd1, 8'd0));
    for (int i = 0; i < 9; i++) begin
      step();
      exp_q.push_back(pin(8'hD5, 1'b1, 2'd3, 4'd1, 8'd1, 8'd0));
    end
    reset_pulse();
    step();
    exp_q.push_back(pin(8'h00, 1'b0, 2'd0, 4'd0, 8'd0, 8'd0));

    // saturation: 20 fetch-miss cycles; 4-bit counter stops at 15
    reset_pulse();
    for (int i = 0; i < 20; i++) begin
      step(); icache_ready_i = 1'b0;
    end
    step(); set_idle();
    exp_q.push_back(pin(8'h00, 1'b0, 2'd1, 4'd15, 8'd20, 8'd0));
    step();
    exp_q.push_back(pin(8'h00, 1'b0, 2'd0, 4'd15, 8'd20, 8'd0));

    // random traffic with periodic resets
    reset_pulse();
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 249) begin
        reset_pulse();
      end else begin
        step();
        drive_random();
      end
    end

    step();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL pinned_queue actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
